dff_input_conditioner: RTL and testbench
========================================

# dff_input_conditioner

Upstream conditioning stage for the `dff` register: it takes an asynchronous, bouncy single-bit input and delivers a clean, clock-aligned level on `d_out`, which drives the `d` pin of the downstream `dff`. Processing is a multi-stage synchronizer followed by a counter-qualified debounce FSM. One-cycle `rise`/`fall` strobes accompany each accepted transition for consumers that need edge events instead of a level.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop count; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, default 4: extra consecutive stable samples required after the first differing sample; legal range ≥ 1.
- Counter width is the derived localparam `$clog2(DEBOUNCE_CYCLES+1)`; it is not a user parameter.

- `clk` input 1: single clock; all state updates on the posedge.
- `rst` input 1: synchronous, active-high reset.
- `raw_in` input 1: asynchronous raw input, e.g. a switch or button.
- `d_out` output 1: debounced level; feeds downstream `dff.d`.
- `rise` output 1: one-cycle pulse when `d_out` goes 0→1.
- `fall` output 1: one-cycle pulse when `d_out` goes 1→0.
- `busy` output 1: high while a candidate transition is being qualified.

## Operation
- **Synchronizer:** chain of `SYNC_STAGES` flops clocked by `clk`; `raw_in` enters stage 0. The last stage is `s`. The FSM reads only `s`.
- **FSM states:** STABLE_LO, CHK_HI, STABLE_HI, CHK_LO. Counter is `cnt`.
- **STABLE_LO** (`d_out`=0):
  - `s`=1 → CHK_HI, `cnt`←0.
  - Otherwise hold.
- **CHK_HI:**
  - `s`=0 → STABLE_LO. Glitch rejected; `d_out` is unchanged and no pulse is generated.
  - `s`=1 and `cnt`==`DEBOUNCE_CYCLES`-1 → STABLE_HI, `d_out`←1, `rise`←1.
  - `s`=1 otherwise → `cnt`←`cnt`+1.
- **STABLE_HI / CHK_LO:** exact mirror of the two states above with polarity inverted; the accepted transition sets `d_out`←0 and `fall`←1.
- **Outputs:**
  - `busy` = state ∈ {CHK_HI, CHK_LO}.
  - `rise` and `fall` are registered, high for exactly one cycle, and never high together.
  - `rise` or `fall` is asserted in the same cycle that `d_out` first shows its new value.
- **Acceptance criterion:** `s` must hold the new value for `DEBOUNCE_CYCLES`+1 consecutive sampled edges (the entry edge plus `DEBOUNCE_CYCLES` counting edges). Any shorter run is discarded.
- **Counter range:** `cnt` never exceeds `DEBOUNCE_CYCLES`-1. `cnt` is don't-care in STABLE states but is held at 0 there.

## Timing
- **Reset values:** synchronizer flops 0, state STABLE_LO, `cnt` 0, `d_out` 0, `rise` 0, `fall` 0, `busy` 0.
- **Reset priority:** reset overrides all other logic. An assertion mid-qualification aborts the qualification; outputs show their reset values after the next edge.
- **After reset release:** an input already high re-qualifies from scratch with full latency.
- **Latency:** `raw_in` settles before edge 0 → `s` reflects it after edge `SYNC_STAGES`-1 → FSM enters CHK after edge `SYNC_STAGES` → `d_out` and the strobe update after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`. With defaults, that is edge 6.
- **Pulse-width threshold:** minimum accepted `raw_in` pulse width is `DEBOUNCE_CYCLES`+1 cycles (5 with defaults); 4 cycles is rejected.
- **Bounce restart:** a bounce during CHK returns the FSM to the STABLE state, and the next differing sample restarts counting from 0. There is no accumulation across bounces.
- **Back-to-back transitions:** from STABLE_HI, a falling input takes the same latency as a rising one. The minimum spacing between a `rise` and the following `fall` is `DEBOUNCE_CYCLES`+1 cycles.
- **Throughput:** no handshake with the downstream `dff`. `d_out` is a level, valid every cycle, and sampled by `dff` on the next posedge.

## Test plan
- **Reset:** assert `rst` for 3 cycles with `raw_in`=1 → `d_out`, `rise`, `fall`, `busy` all 0 throughout. After release, `d_out`=1 at edge 6 after release, `rise`=1 for that one cycle only.
- **Clean rise, defaults:** `raw_in` 0→1 before edge 0 and held → `busy`=1 from edge 2 to edge 5. `d_out`=1 and `rise`=1 after edge 6; `rise`=0 after edge 7.
- **Glitch reject:** `raw_in` high for 4 cycles, then low → `d_out` stays 0, `rise` never asserts, `busy` returns to 0.
- **Threshold accept:** `raw_in` high for exactly 5 cycles → `d_out`=1 with a single `rise`. A `fall` follows 6 cycles after `raw_in` drops, provided the low level holds.
- **Bounce train:** pattern 1,1,0,1,1,1,0,1 then steady 1 → only the final steady run qualifies. A single `rise` occurs 6 cycles after the last 0→1, with no `fall` in between.
- **Reset mid-qualification:** `raw_in`=1, assert `rst` at edge 4 while in CHK_HI → state STABLE_LO, `busy`=0, `d_out`=0. The sequence then re-qualifies with full latency after release.

Source files
------------

// File: rtl/dff_input_conditioner.sv
// Synchronizes and debounces an asynchronous input for the dff d pin.
// Emits one-cycle rise/fall strobes alongside each accepted level change.
module dff_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic d_out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          d_n, rise_n, fall_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE_LO;
      cnt   <= '0;
      d_out <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      d_out <= d_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  end

  // A bounce drops straight back to STABLE so the next run counts from 0.
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    d_n     = d_out;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    unique case (state)
      STABLE_LO: begin
        if (s) state_n = CHK_HI;
      end
      CHK_HI: begin
        if (!s) begin
          state_n = STABLE_LO;
        end else if (cnt == CNT_MAX) begin
          state_n = STABLE_HI;
          d_n     = 1'b1;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!s) state_n = CHK_LO;
      end
      CHK_LO: begin
        if (s) begin
          state_n = STABLE_HI;
        end else if (cnt == CNT_MAX) begin
          state_n = STABLE_LO;
          d_n     = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = STABLE_LO;
        d_n     = 1'b0;
      end
    endcase
  end

  assign busy = (state == CHK_HI) || (state == CHK_LO);

endmodule

// File: tb/tb_dff_input_conditioner.sv
// Self-checking bench for dff_input_conditioner (default parameters).
// Directed table, corner sequences and random traffic against a window model.
module tb_dff_input_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic raw_in;
  logic d_out, rise, fall, busy;

  always #5 clk = ~clk;

  dff_input_conditioner dut (
    .clk    (clk),
    .rst    (rst),
    .raw_in (raw_in),
    .d_out  (d_out),
    .rise   (rise),
    .fall   (fall),
    .busy   (busy)
  );

  typedef struct packed {
    logic d;
    logic r;
    logic f;
    logic b;
  } exp_t;

  typedef struct packed {
    logic rst;
    logic raw;
    exp_t e;
  } vec_t;

  exp_t q[$];
  vec_t vecs[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_rise = 0;
  int n_fall = 0;

  // Reference: d_out flips once the last five synchronized samples
  // all differ from it; busy while the newest sample differs.
  logic [1:0] m_sync = '0;
  logic [4:0] m_hist = '0;
  logic       m_d    = 1'b0;

  function automatic exp_t model(input logic r, input logic x);
    exp_t e;
    logic prev, smp;
    if (r) begin
      m_sync = '0;
      m_hist = '0;
      m_d    = 1'b0;
      e      = '0;
    end else begin
      prev   = m_d;
      smp    = m_sync[1];
      m_sync = {m_sync[0], x};
      m_hist = {m_hist[3:0], smp};
      if (m_hist == {5{~m_d}}) m_d = ~m_d;
      e.d = m_d;
      e.r = m_d & ~prev;
      e.f = ~m_d & prev;
      e.b = m_hist[0] ^ m_d;
    end
    return e;
  endfunction

  function automatic vec_t mk(input logic r, input logic x,
                              input logic d, input logic rs,
                              input logic fl, input logic b);
    vec_t v;
    v.rst = r;
    v.raw = x;
    v.e   = '{d: d, r: rs, f: fl, b: b};
    return v;
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic x, input exp_t e);
    exp_t g;
    rst    = r;
    raw_in = x;
    q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    g = q.pop_front();
    chk("d_out", d_out, g.d);
    chk("rise", rise, g.r);
    chk("fall", fall, g.f);
    chk("busy", busy, g.b);
    chk("rise_fall_excl", rise & fall, 1'b0);
    if (rise === 1'b1) n_rise++;
    if (fall === 1'b1) n_fall++;
  endtask

  task automatic run(input logic r, input logic x);
    step(r, x, model(r, x));
  endtask

  task automatic run_n(input logic r, input logic x, input int n);
    for (int i = 0; i < n; i++) run(r, x);
  endtask

  initial begin
    exp_t me;
    int   len;
    logic lvl;

    rst    = 1'b1;
    raw_in = 1'b0;
    #2;
    run_n(1'b1, 1'b0, 2);

    // reset with input high, then clean rise and fall
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      me = model(vecs[i].rst, vecs[i].raw);
      step(vecs[i].rst, vecs[i].raw, vecs[i].e);
    end
    chk_int("table_rises", n_rise, 1);
    chk_int("table_falls", n_fall, 1);

    // glitch: four cycles high is rejected
    n_rise = 0;
    run_n(1'b0, 1'b1, 4);
    run_n(1'b0, 1'b0, 10);
    chk_int("glitch_rises", n_rise, 0);
    chk("glitch_idle", busy, 1'b0);

    // threshold: five cycles high is accepted, then falls
    n_rise = 0;
    n_fall = 0;
    run_n(1'b0, 1'b1, 5);
    run_n(1'b0, 1'b0, 12);
    chk_int("thresh_rises", n_rise, 1);
    chk_int("thresh_falls", n_fall, 1);

    // bounce train then steady high
    n_rise = 0;
    n_fall = 0;
    run(0, 1); run(0, 1); run(0, 0); run(0, 1);
    run(0, 1); run(0, 1); run(0, 0); run(0, 1);
    run_n(1'b0, 1'b1, 12);
    chk_int("bounce_rises", n_rise, 1);
    chk_int("bounce_falls", n_fall, 0);
    chk("bounce_level", d_out, 1'b1);
    run_n(1'b0, 1'b0, 12);

    // reset in the middle of qualification
    n_rise = 0;
    run_n(1'b0, 1'b1, 4);
    chk("mid_busy_pre", busy, 1'b1);
    run(1'b1, 1'b1);
    chk("mid_busy_rst", busy, 1'b0);
    chk("mid_d_rst", d_out, 1'b0);
    run_n(1'b0, 1'b1, 5);
    chk("mid_requal_d", d_out, 1'b0);
    run_n(1'b0, 1'b1, 3);
    chk_int("mid_rises", n_rise, 1);
    chk("mid_requal_level", d_out, 1'b1);

    // random runs of varying length with occasional reset
    for (int k = 0; k < 60; k++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 19) == 0) run(1'b1, lvl);
      run_n(1'b0, lvl, len);
    end
    run_n(1'b0, 1'b0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
